// File: rtl/shift_acc_seq.sv
// Tile sequencer for a shift_accumulator: buffers one pass of partial sums, bursts it
// gap-free into the accumulator with init/done marking, then drains the finished tile.
module shift_acc_seq #(
  parameter int STAGE_NUM  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int PASS_W     = 8,
  localparam int CW        = $clog2(STAGE_NUM + 1),
  localparam int PW        = $clog2(STAGE_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [CW-1:0]         cfg_len_i,
  input  logic [PASS_W-1:0]     cfg_passes_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic [DATA_WIDTH-1:0] acc_data_o,
  output logic                  acc_valid_o,
  output logic                  acc_init_o,
  output logic                  acc_done_o,
  output logic [PW-1:0]         acc_read_ptr_o,
  input  logic [DATA_WIDTH-1:0] acc_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {PRIME, PGAP, IDLE, FILL, BURST, GAP, DRAIN} state_t;

  localparam logic [CW-1:0]     LEN_MAX = CW'(STAGE_NUM);
  localparam logic [CW-1:0]     ONE_C   = CW'(1);
  localparam logic [PASS_W-1:0] ONE_P   = PASS_W'(1);

  state_t                  state;
  logic [CW-1:0]           len, wcnt, bcnt, rcnt;
  logic [PASS_W-1:0]       passes, pass_cnt;
  logic [DATA_WIDTH-1:0]   mem [STAGE_NUM];
  logic [CW-1:0]           rcnt_nx;
  logic                    last_pass;

  assign out_data_o = acc_data_i;
  assign rcnt_nx    = rcnt + ONE_C;
  assign last_pass  = (pass_cnt == passes - ONE_P);

  // Pass buffer has no reset; contents are only read after a full FILL.
  always_ff @(posedge clk) begin
    if (state == FILL && in_valid_i && in_ready_o)
      mem[wcnt[PW-1:0]] <= in_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= PRIME;
      len            <= '0;
      passes         <= '0;
      wcnt           <= '0;
      bcnt           <= '0;
      rcnt           <= '0;
      pass_cnt       <= '0;
      cfg_ready_o    <= 1'b0;
      in_ready_o     <= 1'b0;
      acc_data_o     <= '0;
      acc_valid_o    <= 1'b0;
      acc_init_o     <= 1'b0;
      acc_done_o     <= 1'b0;
      acc_read_ptr_o <= '0;
      out_valid_o    <= 1'b0;
      out_last_o     <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      case (state)
        // One init beat then a drop: the accumulator's write_ptr lands on 0.
        PRIME: begin
          busy_o <= 1'b1;
          if (!acc_valid_o) begin
            acc_valid_o <= 1'b1;
            acc_init_o  <= 1'b1;
            acc_data_o  <= '0;
          end else begin
            acc_valid_o <= 1'b0;
            acc_init_o  <= 1'b0;
            state       <= PGAP;
          end
        end
        PGAP: begin
          state       <= IDLE;
          cfg_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
        IDLE: begin
          if (cfg_valid_i) begin
            len         <= (cfg_len_i == '0 || cfg_len_i > LEN_MAX) ? LEN_MAX : cfg_len_i;
            passes      <= (cfg_passes_i == '0) ? ONE_P : cfg_passes_i;
            wcnt        <= '0;
            pass_cnt    <= '0;
            cfg_ready_o <= 1'b0;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b1;
            state       <= FILL;
          end
        end
        FILL: begin
          if (in_valid_i) begin
            wcnt <= wcnt + ONE_C;
            if (wcnt == len - ONE_C) begin
              // Launch beat 0 now so the burst has no leading bubble.
              in_ready_o  <= 1'b0;
              acc_valid_o <= 1'b1;
              acc_data_o  <= (len == ONE_C) ? in_data_i : mem[0];
              acc_init_o  <= (pass_cnt == '0);
              acc_done_o  <= (len == ONE_C) && last_pass;
              bcnt        <= ONE_C;
              state       <= BURST;
            end
          end
        end
        BURST: begin
          if (bcnt == len) begin
            acc_valid_o <= 1'b0;
            acc_init_o  <= 1'b0;
            acc_done_o  <= 1'b0;
            pass_cnt    <= pass_cnt + ONE_P;
            state       <= GAP;
          end else begin
            acc_data_o <= mem[bcnt[PW-1:0]];
            acc_done_o <= (bcnt == len - ONE_C) && last_pass;
            bcnt       <= bcnt + ONE_C;
          end
        end
        GAP: begin
          if (pass_cnt < passes) begin
            wcnt       <= '0;
            in_ready_o <= 1'b1;
            state      <= FILL;
          end else begin
            rcnt           <= '0;
            acc_read_ptr_o <= '0;
            out_valid_o    <= 1'b1;
            out_last_o     <= (len == ONE_C);
            state          <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready_i) begin
            if (out_last_o) begin
              out_valid_o    <= 1'b0;
              out_last_o     <= 1'b0;
              acc_read_ptr_o <= '0;
              cfg_ready_o    <= 1'b1;
              busy_o         <= 1'b0;
              state          <= IDLE;
            end else begin
              rcnt           <= rcnt_nx;
              acc_read_ptr_o <= rcnt_nx[PW-1:0];
              out_last_o     <= (rcnt_nx == len - ONE_C);
            end
          end
        end
        default: state <= PRIME;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_acc_seq.sv
// Bench for shift_acc_seq: table of tiles plus reset/replay sequences, with a
// behavioural shift_accumulator model closing the loop on acc_* ports.
module tb_shift_acc_seq;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cfg_valid = 1'b0, cfg_ready;
  logic [4:0]  cfg_len = '0;
  logic [7:0]  cfg_passes = '0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_data = '0;
  logic [31:0] acc_data, acc_q;
  logic        acc_valid, acc_init, acc_done;
  logic [3:0]  acc_ptr;
  logic        out_valid, out_ready = 1'b0, out_last, busy;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  shift_acc_seq dut (
    .clk(clk), .rst(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_len_i(cfg_len), .cfg_passes_i(cfg_passes),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .acc_data_o(acc_data), .acc_valid_o(acc_valid), .acc_init_o(acc_init), .acc_done_o(acc_done),
    .acc_read_ptr_o(acc_ptr), .acc_data_i(acc_q),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
    .busy_o(busy)
  );

  // Accumulator model: write_ptr clears whenever input_valid is low.
  logic [31:0] amem [16];
  logic [3:0]  wp = '0;
  always_ff @(posedge clk) begin
    if (acc_valid) begin
      amem[wp] <= acc_init ? acc_data : amem[wp] + acc_data;
      wp       <= wp + 4'd1;
    end else begin
      wp <= '0;
    end
  end
  assign acc_q = amem[acc_ptr];

  typedef struct {
    int len_cfg; int passes_cfg; int eff; int peff; int base; int ofs; bit in_stall; bit out_stall;
  } tile_t;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Burst monitor: one record per contiguous acc_valid run.
  int cur_base = 0, cur_ofs = 0;
  int run_len = 0, run_init = 0, run_done = 0, run_dpos = 0, run_bad = 0;
  int q_len[$], q_init[$], q_done[$], q_dpos[$], q_bad[$];
  always @(negedge clk) begin
    if (acc_valid) begin
      if ($signed(acc_data) != cur_base * (run_len + 1) + cur_ofs) run_bad++;
      run_len++;
      if (acc_init) run_init++;
      if (acc_done) begin run_done++; run_dpos = run_len; end
    end else if (run_len > 0) begin
      q_len.push_back(run_len); q_init.push_back(run_init); q_done.push_back(run_done);
      q_dpos.push_back(run_dpos); q_bad.push_back(run_bad);
      run_len = 0; run_init = 0; run_done = 0; run_dpos = 0; run_bad = 0;
    end
  end

  task automatic chk_all_zero(input string nm);
    chk(nm, {acc_valid, acc_init, acc_done, cfg_ready, in_ready, out_valid, out_last, busy}, 0);
    chk({nm, "_data"}, {acc_data, acc_ptr}, 0);
  endtask

  // Expects rst high on entry; releases it and checks PRIME, PGAP, IDLE.
  task automatic reset_seq();
    @(negedge clk);
    chk_all_zero("reset_outs");
    rst = 1'b0;
    @(negedge clk);
    chk("prime_valid", acc_valid, 1);
    chk("prime_init", acc_init, 1);
    chk("prime_data", acc_data, 0);
    chk("prime_cfg_ready", cfg_ready, 0);
    @(negedge clk);
    chk("pgap_valid", acc_valid, 0);
    chk("pgap_cfg_ready", cfg_ready, 0);
    @(negedge clk);
    chk("idle_cfg_ready", cfg_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  task automatic cfg_tile(input tile_t t);
    int cyc = 0;
    while (!cfg_ready && cyc < 500) begin @(negedge clk); cyc++; end
    chk("cfg_wait", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_len = 5'(t.len_cfg); cfg_passes = 8'(t.passes_cfg);
    q_len.delete(); q_init.delete(); q_done.delete(); q_dpos.delete(); q_bad.delete();
    cur_base = t.base; cur_ofs = t.ofs;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("cfg_busy", busy, 1);
    chk("cfg_in_ready", in_ready, 1);
  endtask

  task automatic feed(input tile_t t);
    int k = 0, cyc = 0;
    int total = t.eff * t.peff;
    while (k < total && cyc < 2000) begin
      in_valid = t.in_stall ? (cyc % 2 == 0) : 1'b1;
      in_data  = 32'(t.base * ((k % t.eff) + 1) + t.ofs);
      if (in_valid && in_ready) k++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("feed_beats", k, total);
  endtask

  task automatic drain_check(input tile_t t);
    int idx = 0, cyc = 0, stalls = 0;
    while (idx < t.eff && cyc < 3000) begin
      out_ready = 1'b1;
      if (t.out_stall && out_valid && idx == 3 && stalls < 5) begin
        out_ready = 1'b0;
        stalls++;
        chk("stall_ptr", acc_ptr, 3);
        chk("stall_data", $signed(out_data), t.peff * (t.base * 4 + t.ofs));
      end
      if (out_valid && out_ready) begin
        chk("drain_ptr", acc_ptr, idx);
        chk("drain_data", $signed(out_data), t.peff * (t.base * (idx + 1) + t.ofs));
        chk("drain_last", out_last, (idx == t.eff - 1) ? 1 : 0);
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_count", idx, t.eff);
    chk("drain_done_valid", out_valid, 0);
    chk("b2b_cfg_ready", cfg_ready, 1);
  endtask

  task automatic burst_check(input tile_t t);
    chk("burst_runs", q_len.size(), t.peff);
    for (int r = 0; r < q_len.size() && r < t.peff; r++) begin
      chk("burst_len", q_len[r], t.eff);
      chk("burst_init", q_init[r], (r == 0) ? t.eff : 0);
      chk("burst_done", q_done[r], (r == t.peff - 1) ? 1 : 0);
      if (r == t.peff - 1) chk("burst_done_pos", q_dpos[r], t.eff);
      chk("burst_data", q_bad[r], 0);
    end
  endtask

  tile_t tv[7];

  initial begin
    tile_t t;
    int cyc;
    //         len pas eff peff base ofs ins outs
    tv[0] = '{ 4,  1,  4,  1,   1,   0, 0, 0};
    tv[1] = '{ 3,  3,  3,  3,  10,   0, 0, 0};
    tv[2] = '{16,  1, 16,  1,   3,   1, 1, 0};
    tv[3] = '{ 8,  2,  8,  2,   5,   0, 0, 1};
    tv[4] = '{ 0,  0, 16,  1,   1, 100, 0, 0};
    tv[5] = '{20,  1, 16,  1,  -3,   0, 0, 0};
    tv[6] = '{ 1,  4,  1,  4,   7,   0, 0, 0};

    reset_seq();
    for (int i = 0; i < 7; i++) begin
      cfg_tile(tv[i]);
      feed(tv[i]);
      drain_check(tv[i]);
      burst_check(tv[i]);
    end

    // Async reset in the middle of the second pass's burst.
    t = '{5, 2, 5, 2, 1, 0, 0, 0};
    cfg_tile(t);
    feed(t);
    cyc = 0;
    while (!(acc_valid && !acc_init) && cyc < 200) begin @(negedge clk); cyc++; end
    chk("pass1_burst_seen", acc_valid && !acc_init, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_all_zero("midrst_outs");
    reset_seq();
    t = '{2, 1, 2, 1, 2, 5, 0, 0};
    cfg_tile(t);
    feed(t);
    drain_check(t);
    burst_check(t);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
